// File: rtl/avalon_bm_pkg.sv
// Shared constants and types for the Avalon bus matrix slave-port arbiter.
package avalon_bm_pkg;

  localparam int         NUM_MST = 3;
  localparam logic [2:0] IDLE_ID = 3'h7;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/avalon_rr_pick3.sv
// Combinational three-way round-robin picker: search starts one past the last
// winner, and requesters set in the exclude mask are skipped.
module avalon_rr_pick3
  import avalon_bm_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic [2:0] excl,
  output logic       valid,
  output logic [1:0] winner
);

  logic [2:0] cand;
  logic [1:0] start;
  int         idx;

  always_comb begin
    cand   = req & ~excl;
    start  = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    valid  = 1'b0;
    winner = 2'd0;
    idx    = 0;
    // Walk from the farthest offset back to the start so the nearest hit wins.
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (cand[idx]) begin
        valid  = 1'b1;
        winner = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/avalon_bus_matrix_arbiter.sv
// Slave-port arbiter: grants one of three master decoders round-robin, muxes the
// granted command onto the slave and broadcasts the granted ID on PortSel_o.
module avalon_bus_matrix_arbiter
  import avalon_bm_pkg::*;
#(
  parameter logic       Mst0En  = 1'b1,
  parameter logic       Mst1En  = 1'b1,
  parameter logic       Mst2En  = 1'b1,
  parameter int         HoldMax = 4,
  parameter logic [2:0] IdleID  = IDLE_ID
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         Req0_i,
  input  logic [63:0]  Addr0_i,
  input  logic         RdEn0_i,
  input  logic         WrEn0_i,
  input  logic [511:0] WrData0_i,
  input  logic         Req1_i,
  input  logic [63:0]  Addr1_i,
  input  logic         RdEn1_i,
  input  logic         WrEn1_i,
  input  logic [511:0] WrData1_i,
  input  logic         Req2_i,
  input  logic [63:0]  Addr2_i,
  input  logic         RdEn2_i,
  input  logic         WrEn2_i,
  input  logic [511:0] WrData2_i,
  input  logic         WaitReq_i,
  output logic [63:0]  Addr_o,
  output logic         RdEn_o,
  output logic         WrEn_o,
  output logic [511:0] WrData_o,
  output logic [2:0]   PortSel_o
);

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [2:0]   eff;
  logic [2:0]   own_mask;
  logic [2:0]   others;
  logic         other_pend;
  logic         sel_req, sel_rd, sel_wr;
  logic [63:0]  sel_addr;
  logic [511:0] sel_wdata;
  logic         accept, hold_hit, release_now;
  logic         pick_valid;
  logic [1:0]   pick_winner;

  assign eff = {Req2_i & Mst2En, Req1_i & Mst1En, Req0_i & Mst0En};

  always_comb begin
    sel_req   = Req0_i;
    sel_rd    = RdEn0_i;
    sel_wr    = WrEn0_i;
    sel_addr  = Addr0_i;
    sel_wdata = WrData0_i;
    own_mask  = 3'b001;
    case (grant)
      2'd1: begin
        sel_req   = Req1_i;
        sel_rd    = RdEn1_i;
        sel_wr    = WrEn1_i;
        sel_addr  = Addr1_i;
        sel_wdata = WrData1_i;
        own_mask  = 3'b010;
      end
      2'd2: begin
        sel_req   = Req2_i;
        sel_rd    = RdEn2_i;
        sel_wr    = WrEn2_i;
        sel_addr  = Addr2_i;
        sel_wdata = WrData2_i;
        own_mask  = 3'b100;
      end
      default: ;
    endcase
  end

  assign others     = eff & ~own_mask;
  assign other_pend = |others;
  assign accept     = (state == ST_GRANT) && sel_req && !WaitReq_i;
  assign hold_hit   = ({1'b0, cnt} + 5'd1) >= 5'(HoldMax);
  // A stalled command (sel_req & WaitReq_i) can never release: both terms need !stall.
  assign release_now = (state == ST_GRANT) &&
                       (!sel_req || (accept && hold_hit && other_pend));

  avalon_rr_pick3 u_pick (
    .req    (eff),
    .last   (last),
    .excl   ((state == ST_GRANT) ? own_mask : 3'b000),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      grant <= 2'd0;
      last  <= 2'd2;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick_winner;
          last_nxt  = pick_winner;
          cnt_nxt   = 4'd0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          cnt_nxt = 4'd0;
          if (pick_valid) begin
            grant_nxt = pick_winner;
            last_nxt  = pick_winner;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (accept && (cnt != 4'(HoldMax))) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PortSel_o = IdleID;
    Addr_o    = '0;
    RdEn_o    = 1'b0;
    WrEn_o    = 1'b0;
    WrData_o  = '0;
    if (state == ST_GRANT) begin
      PortSel_o = {1'b0, grant};
      Addr_o    = sel_addr;
      RdEn_o    = sel_rd & sel_req;
      WrEn_o    = sel_wr & sel_req;
      WrData_o  = sel_wdata;
    end
  end

endmodule

// File: tb/tb_avalon_bus_matrix_arbiter.sv
// Bench for avalon_bus_matrix_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model for two enable configurations.
module tb_avalon_bus_matrix_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   req, rd, wr;
  logic [63:0]  addr [3];
  logic [511:0] wdata [3];
  logic         wait_req;

  logic [63:0]  a_addr, b_addr;
  logic         a_rd, b_rd, a_wr, b_wr;
  logic [511:0] a_wd, b_wd;
  logic [2:0]   a_ps, b_ps;

  int checks = 0;
  int failures = 0;

  // Reference state per instance: granted master (-1 = none), last winner, hold count.
  int         mg [2];
  int         ml [2];
  int         mc [2];
  logic [2:0] en_mask [2];

  avalon_bus_matrix_arbiter #(.HoldMax(HOLD)) dut_a (
    .clk(clk), .rstn(rstn),
    .Req0_i(req[0]), .Addr0_i(addr[0]), .RdEn0_i(rd[0]), .WrEn0_i(wr[0]), .WrData0_i(wdata[0]),
    .Req1_i(req[1]), .Addr1_i(addr[1]), .RdEn1_i(rd[1]), .WrEn1_i(wr[1]), .WrData1_i(wdata[1]),
    .Req2_i(req[2]), .Addr2_i(addr[2]), .RdEn2_i(rd[2]), .WrEn2_i(wr[2]), .WrData2_i(wdata[2]),
    .WaitReq_i(wait_req),
    .Addr_o(a_addr), .RdEn_o(a_rd), .WrEn_o(a_wr), .WrData_o(a_wd), .PortSel_o(a_ps)
  );

  avalon_bus_matrix_arbiter #(.HoldMax(HOLD), .Mst1En(1'b0)) dut_b (
    .clk(clk), .rstn(rstn),
    .Req0_i(req[0]), .Addr0_i(addr[0]), .RdEn0_i(rd[0]), .WrEn0_i(wr[0]), .WrData0_i(wdata[0]),
    .Req1_i(req[1]), .Addr1_i(addr[1]), .RdEn1_i(rd[1]), .WrEn1_i(wr[1]), .WrData1_i(wdata[1]),
    .Req2_i(req[2]), .Addr2_i(addr[2]), .RdEn2_i(rd[2]), .WrEn2_i(wr[2]), .WrData2_i(wdata[2]),
    .WaitReq_i(wait_req),
    .Addr_o(b_addr), .RdEn_o(b_rd), .WrEn_o(b_wr), .WrData_o(b_wd), .PortSel_o(b_ps)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] m, input int last);
    for (int i = 1; i <= 3; i++) begin
      int idx;
      idx = (last + i) % 3;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_next(input int k, output int g, output int l, output int c);
    logic [2:0] eff, own, others;
    int w;
    bit reqg, acc, rel;
    eff = req & en_mask[k];
    g = mg[k];
    l = ml[k];
    c = mc[k];
    if (g < 0) begin
      w = pick(eff, l);
      if (w >= 0) begin
        g = w;
        l = w;
        c = 0;
      end
    end else begin
      own = 3'b000;
      own[g] = 1'b1;
      others = eff & ~own;
      reqg = req[g];
      acc = reqg && !wait_req;
      rel = !reqg || (acc && (c + 1 >= HOLD) && (others != 3'b000));
      if (rel) begin
        w = pick(others, g);
        g = w;
        if (w >= 0) l = w;
        c = 0;
      end else if (acc && c < HOLD) begin
        c = c + 1;
      end
    end
  endtask

  task automatic check_inst(input int k, input string n, input logic [2:0] ps,
                            input logic [63:0] ad, input logic r, input logic w,
                            input logic [511:0] wd);
    int g;
    logic [2:0]   eps;
    logic [63:0]  ea;
    logic         er, ew;
    logic [511:0] ewd;
    g = mg[k];
    if (g < 0) begin
      eps = 3'h7; ea = '0; er = 1'b0; ew = 1'b0; ewd = '0;
    end else begin
      eps = 3'(g);
      ea  = addr[g];
      er  = rd[g] & req[g];
      ew  = wr[g] & req[g];
      ewd = wdata[g];
    end
    chk({n, "_ps"}, ps, eps);
    chk({n, "_addr"}, ad, ea);
    chk({n, "_rd"}, r, er);
    chk({n, "_wr"}, w, ew);
    chk({n, "_wdata"}, wd, ewd);
  endtask

  task automatic step();
    int g0, l0, c0, g1, l1, c1;
    model_next(0, g0, l0, c0);
    model_next(1, g1, l1, c1);
    @(posedge clk);
    mg[0] = g0; ml[0] = l0; mc[0] = c0;
    mg[1] = g1; ml[1] = l1; mc[1] = c1;
    #2;
    check_inst(0, "a", a_ps, a_addr, a_rd, a_wr, a_wd);
    check_inst(1, "b", b_ps, b_addr, b_rd, b_wr, b_wd);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mg[k] = -1;
      ml[k] = 2;
      mc[k] = 0;
    end
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < 3; i++) begin
      addr[i] = {$urandom, $urandom};
      for (int j = 0; j < 16; j++) wdata[i][j*32 +: 32] = $urandom;
    end
  endtask

  task automatic do_reset();
    req = 3'b000; rd = 3'b000; wr = 3'b000; wait_req = 1'b0;
    rstn = 1'b0;
    model_reset();
    #7;
    chk("rst_ps_a", a_ps, 3'h7);
    chk("rst_ps_b", b_ps, 3'h7);
    chk("rst_addr", a_addr, 64'h0);
    chk("rst_wdata", a_wd, 512'h0);
    chk("rst_rdwr", {a_rd, a_wr}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int seq_a[$], cnt_a[$], seq_b[$], cnt_b[$];
  int idle_a, idle_b;
  int exp_a [4];
  int exp_b [4];
  logic [63:0] held_addr;

  initial begin
    en_mask[0] = 3'b111;
    en_mask[1] = 3'b101;
    randomize_payload();
    do_reset();

    // Single requester: master 1 alone
    addr[1] = 64'h200;
    req = 3'b010; rd = 3'b010;
    step();
    chk("single_ps", a_ps, 3'd1);
    chk("single_rd", a_rd, 1'b1);
    chk("single_addr", a_addr, 64'h200);
    chk("single_dis_ps", b_ps, 3'h7);
    req = 3'b000;
    step();
    chk("single_idle", a_ps, 3'h7);

    // Full contention from reset
    do_reset();
    randomize_payload();
    req = 3'b111; rd = 3'b101; wr = 3'b010;
    idle_a = 0; idle_b = 0;
    for (int n = 0; n < 48; n++) begin
      step();
      if (a_ps == 3'h7) idle_a++;
      else begin
        if (seq_a.size() == 0 || seq_a[seq_a.size()-1] != int'(a_ps)) begin
          seq_a.push_back(int'(a_ps));
          cnt_a.push_back(0);
        end
        if (req[a_ps[1:0]] && !wait_req) cnt_a[cnt_a.size()-1] = cnt_a[cnt_a.size()-1] + 1;
      end
      if (b_ps == 3'h7) idle_b++;
      else begin
        if (seq_b.size() == 0 || seq_b[seq_b.size()-1] != int'(b_ps)) begin
          seq_b.push_back(int'(b_ps));
          cnt_b.push_back(0);
        end
        if (req[b_ps[1:0]] && !wait_req) cnt_b[cnt_b.size()-1] = cnt_b[cnt_b.size()-1] + 1;
      end
    end
    exp_a = '{0, 1, 2, 0};
    exp_b = '{0, 2, 0, 2};
    chk("order_a_len", seq_a.size() >= 4, 1'b1);
    chk("order_b_len", seq_b.size() >= 4, 1'b1);
    if (seq_a.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("order_a", 32'(seq_a[i]), 32'(exp_a[i]));
      for (int i = 0; i < 3; i++) chk("hold_a", 32'(cnt_a[i]), 32'(HOLD));
    end
    if (seq_b.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("order_b", 32'(seq_b[i]), 32'(exp_b[i]));
      for (int i = 0; i < 3; i++) chk("hold_b", 32'(cnt_b[i]), 32'(HOLD));
    end
    chk("idle_a", 32'(idle_a), 32'd0);
    chk("idle_b", 32'(idle_b), 32'd0);

    // Stalled slave while master 2 waits
    do_reset();
    randomize_payload();
    held_addr = addr[0];
    req = 3'b101; rd = 3'b001; wait_req = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("wait_ps", a_ps, 3'd0);
      chk("wait_addr", a_addr, held_addr);
    end
    wait_req = 1'b0;
    step();
    chk("wait_accept_ps", a_ps, 3'd0);
    req = 3'b100;
    step();
    chk("wait_switch_ps", a_ps, 3'd2);

    // Asynchronous reset during a write burst
    do_reset();
    req = 3'b001; wr = 3'b001;
    step();
    step();
    chk("burst_wr", a_wr, 1'b1);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_wr", a_wr, 1'b0);
    chk("arst_ps", a_ps, 3'h7);
    chk("arst_ps_b", b_ps, 3'h7);
    req = 3'b111;
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("post_rst_ps", a_ps, 3'd0);

    // Release and new request in the same cycle
    do_reset();
    req = 3'b001;
    step();
    chk("ovl_ps0", a_ps, 3'd0);
    req = 3'b100;
    step();
    chk("ovl_ps2", a_ps, 3'd2);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      req = 3'($urandom);
      rd = 3'($urandom);
      wr = 3'($urandom);
      wait_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) randomize_payload();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_bus_matrix_arbiter.md
# avalon_bus_matrix_arbiter

Per-slave-port arbiter for the Avalon bus matrix. It shares one slave port among three master-side decoders and grants the port to one requester at a time using round-robin order. It muxes the granted master's command onto the slave and publishes the granted master ID on `PortSel_o`; each master decoder compares that ID against its own to form its waitrequest. One instance sits in front of each slave port.

## Interface
Parameters:
- `Mst0En`, default 1'b1: enables requester 0. A disabled requester is never granted.
- `Mst1En`, default 1'b1: enables requester 1.
- `Mst2En`, default 1'b1: enables requester 2.
- `HoldMax`, default 4: maximum number of accepted transfers per grant while another requester is pending (1..15).
- `IdleID`, default 3'h7: value of `PortSel_o` when nothing is granted. Must not equal 0, 1 or 2.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `Req{0,1,2}_i`  in  1  request from master decoder n (its `Req*_o` for this slave)
- `Addr{0,1,2}_i`  in  64  address from master n
- `RdEn{0,1,2}_i`  in  1  read strobe from master n
- `WrEn{0,1,2}_i`  in  1  write strobe from master n
- `WrData{0,1,2}_i`  in  512  write data from master n
- `WaitReq_i`  in  1  slave waitrequest
- `Addr_o`  out  64  slave address
- `RdEn_o`  out  1  slave read
- `WrEn_o`  out  1  slave write
- `WrData_o`  out  512  slave write data
- `PortSel_o`  out  3  granted master ID (0/1/2) or `IdleID`; broadcast to all decoders

## Operation
- Requester n carries master ID n. An effective request is `ReqN_i & MstNEn`.
- State machine has two states:
  - IDLE: if any effective request is present, pick a winner round-robin starting at `(Last+1) mod 3`. Register the grant, set `Last` to the winner, clear `Cnt`, and go to GRANT. With no request, stay in IDLE.
  - GRANT, with granted index g:
    - A transfer is accepted when `Reqg_i & ~WaitReq_i`. On each accept, `Cnt` increments, saturating at `HoldMax`.
    - Release when `Reqg_i` is low.
    - Also release when `Reqg_i` is high, an accept occurs this cycle, `Cnt+1 >= HoldMax`, and another effective request is pending.
    - On release, if any other effective request is pending, re-arbitrate directly without passing through IDLE. The previous holder is excluded from that pick. Otherwise go to IDLE.
- Never release or switch while `Reqg_i & WaitReq_i` holds. An Avalon command must stay stable until it is accepted.
- Slave command outputs:
  - In GRANT: `Addr_o`/`WrData_o` = master g's values; `RdEn_o` = `RdEngi & Reqg_i`; `WrEn_o` = `WrEngi & Reqg_i`.
  - In IDLE: all slave command outputs are 0.
- The read-data return path is outside this block. Slave read data goes to every decoder, and each decoder selects it with its own registered select.
- If a single requester is alone, it keeps the grant indefinitely. `HoldMax` applies only when there is contention.

## Timing
- Reset values: `PortSel_o`=`IdleID`; `RdEn_o`, `WrEn_o`=0; `Addr_o`, `WrData_o`=0; state IDLE; `Cnt`=0; `Last`=2, so requester 0 has first priority after reset.
- Grant latency: `PortSel_o` and the slave command mux change on the clock edge after the request is sampled. The earliest accept is one cycle after a request first appears.
- Switch latency: the new `PortSel_o` appears on the edge after the release cycle. Back-to-back grants to different masters therefore have zero idle cycles.
- Simultaneous requests from all three masters starting from reset produce the grant order 0, 1, 2, 0, ...
- If `Reqg_i` drops and a new requester rises in the same cycle, that requester is eligible for the immediate re-arbitration.
- Reset asserted mid-transfer: outputs return to their reset values asynchronously and any in-flight transfer is abandoned. After `rstn` rises, arbitration restarts from the reset priority.

## Structure
- Package `avalon_bm_pkg` holds:
  - `IDLE_ID` = 3'h7
  - the state enum {ST_IDLE, ST_GRANT}
  - the `NUM_MST` = 3 constant
- Sub-module `avalon_rr_pick3`: combinational round-robin picker. Inputs are a 3-bit request vector, a 2-bit last index and a 3-bit exclude mask. Outputs are a valid flag and a 2-bit winner.
- Registers in the top: state, grant index, `Last`, `Cnt`. The command mux is combinational from the grant index.

## Test plan
- Single requester: `Req1`=1 with `RdEn1`=1, `Addr1`=0x200, `WaitReq`=0 → cycle+1: `PortSel_o`=1, `RdEn_o`=1, `Addr_o`=0x200. `Req1` low → next cycle `PortSel_o`=7.
- All three request continuously with `HoldMax`=4 and `WaitReq`=0 → each master receives exactly 4 accepts per grant, in grant order 0, 1, 2, 0, with no idle cycles between grants.
- `WaitReq`=1 held for 10 cycles during master 0's transfer while master 2 also requests → `PortSel_o` stays 0 and `Addr_o` is stable. The switch to master 2 occurs only after the accept.
- Disabled port: `Mst1En`=0 and all three request → master 1 is never granted; grant order is 0, 2, 0.
- Asynchronous reset during a write burst → `WrEn_o`=0 and `PortSel_o`=7 immediately. After reset release, with all three requesting, master 0 is granted first.
- Release-and-request overlap: `Req0` falls in the same cycle `Req2` rises → `PortSel_o`=2 on the next edge, with no intermediate `PortSel_o`=7 cycle.
